// File: rtl/computie_bus_initiator.sv
// computie_bus_initiator: single-transfer Computie bus master with synchronized ack and timeout
module computie_bus_initiator #(
  parameter int BITWIDTH    = 32,
  parameter int ADDR_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic                comm_clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [BITWIDTH-1:0] req_addr,
  input  logic [BITWIDTH-1:0] req_wdata,
  output logic                resp_valid,
  output logic [BITWIDTH-1:0] resp_rdata,
  output logic                resp_error,
  output logic                cb_addr_strobe,
  output logic                cb_data_strobe,
  output logic                cb_read_write,
  input  logic                cb_data_ack,
  output logic [BITWIDTH-1:0] cb_addr_data_out,
  output logic                cb_addr_data_oe,
  input  logic [BITWIDTH-1:0] cb_addr_data_in,
  output logic                send_receive,
  output logic                addr_oe,
  output logic                data_oe,
  output logic                data_dir
);
  localparam int CW = $clog2(TIMEOUT > ADDR_CYCLES ? TIMEOUT : ADDR_CYCLES);
  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_TURN, S_DATA, S_END} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic ack_m, ack_s, wr, wr_n, err_n, busy_n, drive_n;
  logic [BITWIDTH-1:0] addr, addr_n, wdata, wdata_n, rdata_n;
  assign req_ready = state == S_IDLE && ack_s;
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    wr_n    = wr;
    addr_n  = addr;
    wdata_n = wdata;
    rdata_n = resp_rdata;
    err_n   = resp_error;
    case (state)
      S_IDLE: begin
        cnt_n = '0;
        if (req_valid && req_ready) begin
          state_n = S_ADDR;
          wr_n    = req_write;
          addr_n  = req_addr;
          wdata_n = req_wdata;
        end
      end
      S_ADDR: if (cnt == CW'(ADDR_CYCLES - 1)) begin
        state_n = wr ? S_DATA : S_TURN;
        cnt_n   = '0;
      end
      S_TURN: begin
        state_n = S_DATA;
        cnt_n   = '0;
      end
      // a synchronized ack takes priority over a timeout in the same cycle
      S_DATA: if (!ack_s) begin
        state_n = S_END;
        rdata_n = wr ? '0 : cb_addr_data_in;
        err_n   = 1'b0;
      end else if (cnt == CW'(TIMEOUT - 1)) begin
        state_n = S_END;
        rdata_n = '0;
        err_n   = 1'b1;
      end
      default: state_n = S_IDLE;
    endcase
  end
  assign busy_n  = state_n inside {S_ADDR, S_TURN, S_DATA};
  assign drive_n = state_n == S_ADDR || (state_n == S_DATA && wr_n);
  // outputs are computed from the next state so they flip on the same edge as the state
  always_ff @(posedge comm_clock or posedge reset) begin
    if (reset) begin
      state            <= S_IDLE;
      cnt              <= '0;
      ack_m            <= 1'b1;
      ack_s            <= 1'b1;
      wr               <= 1'b0;
      addr             <= '0;
      wdata            <= '0;
      cb_addr_strobe   <= 1'b1;
      cb_data_strobe   <= 1'b1;
      cb_read_write    <= 1'b1;
      cb_addr_data_oe  <= 1'b0;
      cb_addr_data_out <= '0;
      send_receive     <= 1'b0;
      addr_oe          <= 1'b0;
      data_oe          <= 1'b0;
      data_dir         <= 1'b0;
      resp_valid       <= 1'b0;
      resp_rdata       <= '0;
      resp_error       <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      ack_m            <= cb_data_ack;
      ack_s            <= ack_m;
      wr               <= wr_n;
      addr             <= addr_n;
      wdata            <= wdata_n;
      cb_addr_strobe   <= !busy_n;
      cb_data_strobe   <= state_n != S_DATA;
      cb_read_write    <= !(busy_n && wr_n);
      cb_addr_data_oe  <= drive_n;
      cb_addr_data_out <= state_n == S_ADDR ? addr_n : (state_n == S_DATA && wr_n) ? wdata_n : '0;
      send_receive     <= drive_n;
      addr_oe          <= state_n == S_ADDR;
      data_oe          <= state_n == S_DATA;
      data_dir         <= state_n == S_DATA && wr_n;
      resp_valid       <= state_n == S_END;
      resp_rdata       <= rdata_n;
      resp_error       <= err_n;
    end
  end
endmodule

// File: tb/tb_computie_bus_initiator.sv
// tb_computie_bus_initiator: directed and random transfers checked against a phase-timeline model
module tb_computie_bus_initiator;
  localparam int W = 32, AC = 2, TO = 64;
  logic comm_clock = 0, reset = 1;
  logic req_valid, req_ready, req_write, resp_valid, resp_error;
  logic [W-1:0] req_addr, req_wdata, resp_rdata, cb_addr_data_out, cb_addr_data_in;
  logic cb_addr_strobe, cb_data_strobe, cb_read_write, cb_data_ack, cb_addr_data_oe;
  logic send_receive, addr_oe, data_oe, data_dir;
  int errors = 0, checks = 0;
  string nm [5] = '{"idle", "addr", "turn", "data", "end"};
  computie_bus_initiator #(.BITWIDTH(W), .ADDR_CYCLES(AC), .TIMEOUT(TO)) dut (
    .comm_clock(comm_clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata), .resp_valid(resp_valid),
    .resp_rdata(resp_rdata), .resp_error(resp_error), .cb_addr_strobe(cb_addr_strobe),
    .cb_data_strobe(cb_data_strobe), .cb_read_write(cb_read_write), .cb_data_ack(cb_data_ack),
    .cb_addr_data_out(cb_addr_data_out), .cb_addr_data_oe(cb_addr_data_oe),
    .cb_addr_data_in(cb_addr_data_in), .send_receive(send_receive), .addr_oe(addr_oe),
    .data_oe(data_oe), .data_dir(data_dir));
  always #5 comm_clock = ~comm_clock;
  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [9:0] obs_vec();
    return {cb_addr_strobe, cb_data_strobe, cb_read_write, cb_addr_data_oe, addr_oe,
            data_oe, data_dir, send_receive, resp_valid, req_ready};
  endfunction
  // {as, ds, rw, bus_oe, addr_oe, data_oe, data_dir, send_receive, resp_valid, req_ready}
  function automatic logic [9:0] exp_vec(input int ph, input bit w, input bit rr);
    case (ph)
      1:       return {2'b01, ~w, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
      2:       return 10'b0110000000;
      3:       return {2'b00, ~w, w, 1'b0, 1'b1, w, w, 2'b00};
      4:       return 10'b1110000010;
      default: return {9'b111000000, rr};
    endcase
  endfunction
  // d: DATA cycle in which the target pulls ack low (>= TO means never); hold: extra idle cycles ack stays low
  task automatic do_txn(input bit w, input logic [W-1:0] a, input logic [W-1:0] wd,
                        input logic [W-1:0] rd, input int d, input int hold, input bit keep);
    bit ok, raw;
    int len, pre, k;
    ok  = d + 2 <= TO - 1;
    len = ok ? d + 3 : TO;
    raw = d < len;
    pre = AC + (w ? 0 : 1);
    req_valid = 1; req_write = w; req_addr = a; req_wdata = wd; cb_addr_data_in = rd;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge comm_clock);
      k++;
    end
    chk("accept_wait", {31'd0, req_ready}, 1);
    @(negedge comm_clock);
    if (!keep) req_valid = 0;
    for (int c = 0; c < pre + len + 1; c++) begin
      int ph, idx;
      ph  = c < AC ? 1 : c < pre ? 2 : c < pre + len ? 3 : 4;
      idx = c - pre;
      chk($sformatf("vec_%s_c%0d", nm[ph], c), {22'd0, obs_vec()}, {22'd0, exp_vec(ph, w, 0)});
      if (ph == 1) chk("bus_addr", cb_addr_data_out, a);
      if (ph == 3 && w) chk("bus_wdata", cb_addr_data_out, wd);
      if (ph == 4) begin
        chk("end_out", cb_addr_data_out, 0);
        chk("resp_rdata", resp_rdata, w ? 32'd0 : ok ? rd : 32'd0);
        chk("resp_error", {31'd0, resp_error}, {31'd0, !ok});
      end
      if (ph == 3 && idx == d) cb_data_ack = 0;
      if (ph == 4 && hold == 0) cb_data_ack = 1;
      @(negedge comm_clock);
    end
    for (int i = 0; i <= hold + 1; i++) begin
      chk($sformatf("vec_idle_i%0d", i), {22'd0, obs_vec()}, {22'd0, exp_vec(0, w, !raw || i >= hold + 1)});
      if (i == hold - 1) cb_data_ack = 1;
      if (i < hold + 1) @(negedge comm_clock);
    end
    chk("rdata_hold", resp_rdata, w ? 32'd0 : ok ? rd : 32'd0);
  endtask
  initial begin
    int k;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    cb_data_ack = 1; cb_addr_data_in = 0;
    repeat (2) @(negedge comm_clock);
    chk("reset_vec", {22'd0, obs_vec()}, {22'd0, exp_vec(0, 0, 1)});
    chk("reset_out", cb_addr_data_out, 0);
    chk("reset_rdata", resp_rdata, 0);
    chk("reset_error", {31'd0, resp_error}, 0);
    reset = 0;
    @(negedge comm_clock);
    do_txn(1, 32'h2020FFFF, 32'hAAAAAAAA, 32'h0, 1, 0, 0);
    do_txn(0, 32'h12345678, 32'h0, 32'h55555555, 2, 0, 0);
    do_txn(0, 32'hDEAD0000, 32'h0, 32'h11111111, 999, 0, 0);
    do_txn(0, 32'h0000BEEF, 32'h0, 32'h33CC33CC, 61, 0, 0);
    do_txn(1, 32'h00000004, 32'h77777777, 32'h0, 62, 1, 0);
    do_txn(1, 32'hCAFE0001, 32'h01234567, 32'h0, 0, 3, 1);
    do_txn(0, 32'hCAFE0002, 32'h0, 32'h89ABCDEF, 3, 0, 0);
    req_valid = 1; req_write = 1; req_addr = 32'h0BAD0BAD; req_wdata = 32'h5A5A5A5A;
    k = 0;
    while (!req_ready && k < 20) begin
      @(negedge comm_clock);
      k++;
    end
    @(negedge comm_clock);
    req_valid = 0;
    repeat (AC + 1) @(negedge comm_clock);
    chk("mid_data_strobe", {31'd0, cb_data_strobe}, 0);
    reset = 1;
    #1;
    chk("async_reset", {28'd0, cb_addr_strobe, cb_data_strobe, cb_addr_data_oe, resp_valid}, 32'b1100);
    @(negedge comm_clock);
    reset = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge comm_clock);
      chk("post_reset_idle", {22'd0, obs_vec()}, {22'd0, exp_vec(0, 0, 1)});
    end
    for (int n = 0; n < 25; n++) begin
      int r, d;
      r = $urandom_range(0, 9);
      d = r == 0 ? 999 : r == 1 ? $urandom_range(58, 64) : $urandom_range(0, 12);
      do_txn($urandom_range(0, 1), $urandom, $urandom, $urandom, d, $urandom_range(0, 2), 0);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/computie_bus_initiator.md
Name: computie_bus_initiator

Overview:
- Active bus master for the Computie bus, the driving counterpart to the passive bus snooper.
- Accepts single read/write requests on a simple valid/ready interface clocked by comm_clock.
- Runs one multiplexed address/data cycle: address phase under cb_addr_strobe, data phase under cb_data_strobe, completion on an active-low acknowledge.
- Drives the external transceiver controls and returns read data or a timeout error.

Parameters:
- BITWIDTH, 32: width of the multiplexed address/data bus and of request address/data.
- ADDR_CYCLES, 2: comm_clock cycles the address is held with cb_addr_strobe low before the data phase (>=1).
- TIMEOUT, 64: maximum comm_clock cycles spent in DATA waiting for acknowledge before the cycle is ended with error (>=4).

Ports:
- comm_clock  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  initiator can accept a request this cycle.
- req_write  input  1  1=write, 0=read.
- req_addr  input  BITWIDTH  transaction address.
- req_wdata  input  BITWIDTH  write data.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  BITWIDTH  read data, valid with resp_valid.
- resp_error  output  1  timeout flag, valid with resp_valid.
- cb_addr_strobe  output  1  active-low address strobe.
- cb_data_strobe  output  1  active-low data strobe.
- cb_read_write  output  1  1=read, 0=write.
- cb_data_ack  input  1  active-low acknowledge from target; asynchronous.
- cb_addr_data_out  output  BITWIDTH  value driven onto the multiplexed bus.
- cb_addr_data_oe  output  1  1=drive cb_addr_data_out onto the bus.
- cb_addr_data_in  input  BITWIDTH  sampled bus value.
- send_receive  output  1  transceiver direction: 1=send, 0=receive.
- addr_oe  output  1  address transceiver enable, active-high.
- data_oe  output  1  data transceiver enable, active-high.
- data_dir  output  1  data transceiver direction: 1=out, 0=in.

Behaviour:
- Reset, asynchronous and immediate, also mid-cycle:
  - state=IDLE.
  - Strobes high, cb_read_write=1.
  - cb_addr_data_oe, addr_oe, data_oe, data_dir, send_receive = 0.
  - cb_addr_data_out=0, resp_valid=0, resp_rdata=0, resp_error=0.
  - Synchronizer flops preset to 1.
- cb_data_ack passes a 2-flop synchronizer, giving ack_s (low = acknowledged). It is used only after synchronization, so 2 cycles of latency.
- All outputs are registered and change on the same edge as the state they belong to.
- IDLE:
  - req_ready = (ack_s==1).
  - On req_valid && req_ready: latch write, addr and wdata; go to ADDR; clear the counter.
  - If ack_s is still low (target has not released), the request is not accepted.
- ADDR:
  - cb_addr_strobe=0, cb_read_write=~write.
  - cb_addr_data_out=addr, cb_addr_data_oe=1, addr_oe=1, send_receive=1.
  - Held exactly ADDR_CYCLES cycles, then go to DATA for a write or TURN for a read.
- TURN (reads only), exactly 1 cycle:
  - cb_addr_strobe stays 0.
  - cb_addr_data_oe=0, addr_oe=0, send_receive=0.
  - Then go to DATA.
- DATA:
  - cb_data_strobe=0, data_oe=1, cb_addr_strobe stays 0.
  - Write: cb_addr_data_out=wdata, cb_addr_data_oe=1, data_dir=1, send_receive=1.
  - Read: cb_addr_data_oe=0, data_dir=0, send_receive=0.
  - The counter increments every DATA cycle.
  - On ack_s==0: capture cb_addr_data_in into resp_rdata (write: resp_rdata=0), resp_error=0, go to END.
  - Else, when the counter reaches TIMEOUT-1: resp_rdata=0, resp_error=1, go to END.
  - If the ack arrives in the same cycle the timeout is reached, the ack wins (no error).
- END, exactly 1 cycle:
  - Both strobes high, cb_read_write=1.
  - All enables 0; cb_addr_data_out=0.
  - resp_valid=1 (only in this cycle).
  - Then go to IDLE.
- The bus is never driven by the initiator during TURN, during read DATA, or in IDLE. No overlap of address-drive and read-receive.
- req_ready is 0 in every state except IDLE. Requests presented while busy are held off, not dropped.
- resp_rdata and resp_error hold their values until the next END.

Test Plan:
- Reset asserted mid-DATA of a write -> same cycle: strobes=1, cb_addr_data_oe=0, req_ready=1 after release with cb_data_ack=1; no resp_valid.
- Write 0x2020FFFF <- 0xAAAAAAAA, ADDR_CYCLES=2; target pulls cb_data_ack low 1 cycle after cb_data_strobe falls ->
  - bus shows 0x2020FFFF for 2 cycles, then 0xAAAAAAAA with cb_read_write=0.
  - resp_valid 4 cycles after DATA entry, resp_error=0.
  - strobes high in that cycle.
- Read 0x12345678; target drives 0x55555555 and acks 2 cycles after the data strobe ->
  - exactly 1 TURN cycle with cb_addr_data_oe=0 and cb_read_write=1.
  - resp_rdata=0x55555555, resp_error=0.
- Read with cb_data_ack held high, TIMEOUT=64 -> resp_valid exactly 64 cycles after DATA entry, resp_error=1, resp_rdata=0, strobes released.
- Back-to-back: second req_valid asserted during the first transaction ->
  - req_ready=0 until IDLE.
  - If the target holds cb_data_ack low after END, the second request is accepted only 2 cycles after ack rises.
- Ack arriving on the timeout cycle -> resp_error=0, data captured.
